packet_builder: RTL and testbench

//  Transmit end of the sequenced stream link. Accepts one parallel payload (<=37 bytes) with stream ID and

---
 rtl/packet_builder.sv | 141 ++++++++++++++
 tb/tb_packet_builder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_builder.sv
// packet_builder: stamps each payload with its stream's next sequence number and serialises it as 32-bit words.
// Optional feature: define PKT_BUILDER_SEQ_SKIP_EN to add the seq_skip port (injects a one-packet sequence gap).
module packet_builder #(
  parameter int NUM_STREAMS       = 32,
  parameter int MAX_PAYLOAD_BYTES = 37,
  parameter int SEQ_W             = 32,
  localparam int STREAM_W  = $clog2(NUM_STREAMS),
  localparam int LEN_W     = $clog2(MAX_PAYLOAD_BYTES + 1),
  localparam int PAYLOAD_W = 8 * MAX_PAYLOAD_BYTES,
  localparam int MAX_WORDS = (MAX_PAYLOAD_BYTES + 3) / 4,
  localparam int WCNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:PAYLOAD_W-1]  dataIn,
  input  logic [LEN_W-1:0]      dataIn_len,
  input  logic [STREAM_W-1:0]   dataIn_stream,
  input  logic                  dataIn_val,
  output logic                  dataIn_ready,
`ifdef PKT_BUILDER_SEQ_SKIP_EN
  input  logic                  seq_skip,
`endif
  output logic [31:0]           dataOut,
  output logic                  dataOut_val,
  input  logic                  dataOut_ready,
  output logic                  dataOut_last,
  output logic                  len_err
);

  // Handshake: a transfer happens on a rising edge where val and ready are both high; a source
  // holding val keeps its data stable until that edge, and never withdraws val before it.

  typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_SEQ, SEND_DATA} state_t;
  state_t state, nextState;

  logic [SEQ_W-1:0]    seqTable [NUM_STREAMS];
  logic [SEQ_W-1:0]    seqReg, seqNew, seqInc;
  logic [LEN_W-1:0]    lenReg;
  logic [STREAM_W-1:0] streamReg;
  logic [WCNT_W-1:0]   wordsLeft, wordsIn;
  logic [LEN_W:0]      lenPlus3;
  logic [0:PAYLOAD_W-1] payloadReg, maskedIn;
  logic                accept, lenErrNext, lenLegal;

  assign lenLegal = (dataIn_len != '0) && (dataIn_len <= LEN_W'(MAX_PAYLOAD_BYTES));
  assign lenPlus3 = {1'b0, dataIn_len} + (LEN_W+1)'(3);
  assign wordsIn  = WCNT_W'(lenPlus3 >> 2);

`ifdef PKT_BUILDER_SEQ_SKIP_EN
  assign seqInc = seq_skip ? SEQ_W'(2) : SEQ_W'(1);
`else
  assign seqInc = SEQ_W'(1);
`endif
  assign seqNew = seqTable[dataIn_stream] + seqInc;

  // Bytes beyond the length are zeroed at capture, so padding in the last word is always clean.
  always_comb begin
    maskedIn = '0;
    for (int i = 0; i < MAX_PAYLOAD_BYTES; i++) begin
      if (i < int'(dataIn_len)) maskedIn[8*i +: 8] = dataIn[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState    = state;
    dataOut      = '0;
    dataOut_val  = 1'b0;
    dataOut_last = 1'b0;
    accept       = 1'b0;
    lenErrNext   = 1'b0;
    case (state)
      IDLE: begin
        if (dataIn_val && dataIn_ready) begin
          if (lenLegal) begin
            accept    = 1'b1;
            nextState = SEND_HDR;
          end else begin
            lenErrNext = 1'b1;
          end
        end
      end
      SEND_HDR: begin
        dataOut_val = 1'b1;
        dataOut     = {16'(lenReg) + 16'd8, {(16-STREAM_W){1'b0}}, streamReg};
        if (dataOut_ready) nextState = SEND_SEQ;
      end
      SEND_SEQ: begin
        dataOut_val = 1'b1;
        dataOut     = seqReg;
        if (dataOut_ready) nextState = SEND_DATA;
      end
      SEND_DATA: begin
        dataOut_val  = 1'b1;
        dataOut      = payloadReg[0:31];
        dataOut_last = (wordsLeft == WCNT_W'(1));
        if (dataOut_ready && dataOut_last) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataIn_ready <= 1'b1;
      len_err      <= 1'b0;
      lenReg       <= '0;
      streamReg    <= '0;
      seqReg       <= '0;
      wordsLeft    <= '0;
      payloadReg   <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) seqTable[i] <= '0;
    end else begin
      len_err <= lenErrNext;
      if (accept) begin
        dataIn_ready              <= 1'b0;
        lenReg                    <= dataIn_len;
        streamReg                 <= dataIn_stream;
        seqReg                    <= seqNew;
        seqTable[dataIn_stream]   <= seqNew;
        payloadReg                <= maskedIn;
        wordsLeft                 <= wordsIn;
      end else if (state == SEND_DATA && dataOut_ready) begin
        // The current word always sits in the top 32 bits; consumed words shift out.
        if (dataOut_last) begin
          payloadReg   <= '0;
          wordsLeft    <= '0;
          dataIn_ready <= 1'b1;
        end else begin
          payloadReg <= {payloadReg[32:PAYLOAD_W-1], 32'h0};
          wordsLeft  <= wordsLeft - WCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_builder.sv
// Self-checking bench for packet_builder: randomized packets checked against a per-stream sequence model.
module tb_packet_builder;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [0:295]  dataIn = '0;
  logic [5:0]    dataIn_len = '0;
  logic [4:0]    dataIn_stream = '0;
  logic          dataIn_val = 1'b0;
  logic          dataIn_ready;
  logic [31:0]   dataOut;
  logic          dataOut_val;
  logic          dataOut_ready = 1'b0;
  logic          dataOut_last;
  logic          len_err;
`ifdef PKT_BUILDER_SEQ_SKIP_EN
  logic          seq_skip = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] modelSeq [32];
  logic [7:0]  payBytes [37];

  packet_builder dut (
    .clk(clk), .reset(reset),
    .dataIn(dataIn), .dataIn_len(dataIn_len), .dataIn_stream(dataIn_stream),
    .dataIn_val(dataIn_val), .dataIn_ready(dataIn_ready),
`ifdef PKT_BUILDER_SEQ_SKIP_EN
    .seq_skip(seq_skip),
`endif
    .dataOut(dataOut), .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready),
    .dataOut_last(dataOut_last), .len_err(len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time (got hang, required finish)");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) modelSeq[i] = 32'h0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    dataIn_val = 1'b0;
    dataOut_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic random_payload();
    for (int i = 0; i < 37; i++) payBytes[i] = 8'($urandom_range(0, 255));
  endtask

  // Caller is at a negedge. readyMode: 0 always ready, 1 toggle 1/0, 2 random.
  // stopAfter > 0 ends collection after that many accepted words.
  task automatic run_packet(input int len, input int stream, input int readyMode, input int stopAfter);
    logic [31:0] seq, w, expw, prevWord;
    logic        prevLast, prevPending, r, expLast;
    int          nWords, total, limit, got, cyc;
    nWords = (len + 3) / 4;
    total  = nWords + 2;
    seq = modelSeq[stream] + 32'd1;
    modelSeq[stream] = seq;
    exp_q.push_back({16'(len + 8), 11'b0, 5'(stream)});
    exp_q.push_back(seq);
    for (int k = 0; k < nWords; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) if (4*k + j < len) w[31-8*j -: 8] = payBytes[4*k + j];
      exp_q.push_back(w);
    end
    for (int i = 0; i < 37; i++) dataIn[8*i +: 8] = payBytes[i];
    dataIn_len = 6'(len);
    dataIn_stream = 5'(stream);
    dataIn_val = 1'b1;
    cyc = 0;
    while (dataIn_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (dataIn_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: dataIn_ready=%b required 1", dataIn_ready);
      dataIn_val = 1'b0;
      exp_q.delete();
      return;
    end
    @(negedge clk);
    dataIn_val = 1'b0;
    for (int i = 0; i < 37; i++) dataIn[8*i +: 8] = 8'($urandom_range(0, 255));
    checks++;
    if (dataOut_val !== 1'b1) begin
      errors++;
      $display("FAIL hdr_latency: dataOut_val=%b required 1 one cycle after accept", dataOut_val);
    end
    rx_q.delete();
    limit = (stopAfter > 0) ? stopAfter : total;
    got = 0;
    cyc = 0;
    prevPending = 1'b0;
    prevWord = '0;
    prevLast = 1'b0;
    while (got < limit && cyc < 200) begin
      case (readyMode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      dataOut_ready = r;
      if (prevPending) begin
        checks++;
        if (dataOut_val !== 1'b1 || dataOut !== prevWord || dataOut_last !== prevLast) begin
          errors++;
          $display("FAIL hold_stable: val=%b word=%h last=%b required val=1 word=%h last=%b",
                   dataOut_val, dataOut, dataOut_last, prevWord, prevLast);
        end
      end
      if (dataOut_val === 1'b1 && r) begin
        expw = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        expLast = (got == total - 1) ? 1'b1 : 1'b0;
        checks++;
        if (dataOut !== expw) begin
          errors++;
          $display("FAIL word%0d: got %h required %h", got, dataOut, expw);
        end
        checks++;
        if (dataOut_last !== expLast) begin
          errors++;
          $display("FAIL last%0d: got %b required %b", got, dataOut_last, expLast);
        end
        rx_q.push_back(dataOut);
        got++;
        prevPending = 1'b0;
      end else if (dataOut_val === 1'b1) begin
        prevPending = 1'b1;
        prevWord = dataOut;
        prevLast = dataOut_last;
      end else begin
        prevPending = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got < limit) begin
      errors++;
      $display("FAIL packet_timeout: got %0d words required %0d", got, limit);
      exp_q.delete();
    end
    if (stopAfter == 0) begin
      checks++;
      if (dataOut_val !== 1'b0 || dataIn_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_gap: val=%b ready=%b required val=0 ready=1", dataOut_val, dataIn_ready);
      end
    end
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] req);
    logic [31:0] act;
    act = (rx_q.size() > idx) ? rx_q[idx] : 32'hXXXXXXXX;
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dataOut_val !== 1'b0 || dataOut_last !== 1'b0 || dataOut !== 32'h0 ||
        len_err !== 1'b0 || dataIn_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: val=%b last=%b data=%h err=%b ready=%b required 0 0 0 0 1",
               dataOut_val, dataOut_last, dataOut, len_err, dataIn_ready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 37; i++) payBytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) payBytes[i] = 8'(i + 1);
    run_packet(5, 3, 0, 0);
    check_word("basic_hdr", 0, 32'h000D0003);
    check_word("basic_seq", 1, 32'h00000001);
    check_word("basic_d0", 2, 32'h01020304);
    check_word("basic_d1", 3, 32'h05000000);
  endtask

  task automatic test_seq_streams();
    random_payload();
    run_packet(8, 3, 0, 0);
    check_word("seq_stream3", 1, 32'h00000002);
    random_payload();
    run_packet(3, 7, 0, 0);
    check_word("seq_stream7", 1, 32'h00000001);
  endtask

  task automatic test_max_len_backpressure();
    random_payload();
    run_packet(37, 12, 1, 0);
    checks++;
    if (rx_q.size() != 12) begin
      errors++;
      $display("FAIL max_len_words: got %0d required 12", rx_q.size());
    end
    dataOut_ready = 1'b1;
  endtask

  task automatic test_len_err();
    int lens[2];
    lens[0] = 0;
    lens[1] = 38;
    foreach (lens[i]) begin
      random_payload();
      dataIn_len = 6'(lens[i]);
      dataIn_stream = 5'd20;
      dataIn_val = 1'b1;
      @(negedge clk);
      dataIn_val = 1'b0;
      checks++;
      if (len_err !== 1'b1 || dataOut_val !== 1'b0) begin
        errors++;
        $display("FAIL len_err_pulse len=%0d: err=%b val=%b required err=1 val=0", lens[i], len_err, dataOut_val);
      end
      @(negedge clk);
      checks++;
      if (len_err !== 1'b0 || dataOut_val !== 1'b0) begin
        errors++;
        $display("FAIL len_err_single len=%0d: err=%b val=%b required err=0 val=0", lens[i], len_err, dataOut_val);
      end
    end
    random_payload();
    run_packet(4, 20, 0, 0);
    check_word("len_err_table", 1, 32'h00000001);
  endtask

  task automatic test_seq_wrap();
    dut.seqTable[0] = 32'hFFFF_FFFE;
    modelSeq[0] = 32'hFFFF_FFFE;
    random_payload();
    run_packet(6, 0, 0, 0);
    check_word("wrap_ffffffff", 1, 32'hFFFFFFFF);
    random_payload();
    run_packet(2, 0, 2, 0);
    check_word("wrap_zero", 1, 32'h00000000);
    dataOut_ready = 1'b1;
  endtask

  task automatic test_reset_midpacket();
    random_payload();
    run_packet(20, 3, 0, 2);
    dataOut_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dataOut_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: dataOut_val=%b required 0", dataOut_val);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (dataOut_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resume: dataOut_val=%b required 0", dataOut_val);
    end
    random_payload();
    run_packet(9, 3, 0, 0);
    check_word("reset_seq", 1, 32'h00000001);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 25; n++) begin
      random_payload();
      run_packet($urandom_range(1, 37), $urandom_range(0, 7), $urandom_range(0, 2), 0);
    end
    dataOut_ready = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_seq_streams();
    test_max_len_backpressure();
    test_len_err();
    test_seq_wrap();
    test_reset_midpacket();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
